// File: rtl/seg_scan_ctrl_if.sv
// Display-data load handshake and scan outputs shared by seg_scan_ctrl and its driver.
interface seg_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value_in;
    logic [NUM_DIGITS-1:0]     blank_in;
    logic [3:0]                nibble_out;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic                      pending;
    logic                      frame_done;

    modport master (
        output load, value_in, blank_in,
        input  nibble_out, digit_en, pending, frame_done
    );

    modport slave (
        input  load, value_in, blank_in,
        output nibble_out, digit_en, pending, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned shadow loading.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the highest nonzero nibble.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 1000,
    parameter int unsigned CNT_W      = 10
) (
    input logic             clk,
    input logic             rst,
    seg_scan_ctrl_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam int unsigned ValW = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [ValW-1:0]       act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
    logic [ValW-1:0]       sh_val_q, sh_val_d;
    logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q, frame_done_d;
    logic [3:0]            nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  dwell_end, frame_end;

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i (i > 0) is dark when it and every digit above it are zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero && (sh_val_q[4*i +: 4] == 4'h0);
            lz_mask[i] = all_zero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign dwell_end = (cnt_q == CNT_W'(PRESCALE - 1));
    assign frame_end = dwell_end && (idx_q == IdxW'(NUM_DIGITS - 1));

    always_comb begin
        cnt_d        = dwell_end ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        act_val_d    = act_val_q;
        act_blank_d  = act_blank_q;
        sh_val_d     = sh_val_q;
        sh_blank_d   = sh_blank_q;
        pending_d    = pending_q;
        frame_done_d = frame_end;

        if (dwell_end) begin
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end

        // Transfer uses the old shadow, so a load on this same edge waits a frame.
        if (frame_end && pending_q) begin
            act_val_d   = sh_val_q;
            act_blank_d = sh_blank_q | lz_mask;
            pending_d   = 1'b0;
        end

        if (bus.load) begin
            sh_val_d   = bus.value_in;
            sh_blank_d = bus.blank_in;
            pending_d  = 1'b1;
        end

        nibble_d   = act_val_d[4*idx_d +: 4];
        digit_en_d = '1;
        // Count 0 of each dwell is a dead cycle to avoid ghosting on digit change.
        if ((cnt_d != '0) && !act_blank_d[idx_d]) begin
            digit_en_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_val_q    <= '0;
            act_blank_q  <= '1;
            sh_val_q     <= '0;
            sh_blank_q   <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            nibble_q     <= 4'h0;
            digit_en_q   <= '1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_val_q    <= act_val_d;
            act_blank_q  <= act_blank_d;
            sh_val_q     <= sh_val_d;
            sh_blank_q   <= sh_blank_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            nibble_q     <= nibble_d;
            digit_en_q   <= digit_en_d;
        end
    end

    assign bus.nibble_out = nibble_q;
    assign bus.digit_en   = digit_en_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, PRESCALE=4.
module tb_seg_scan_ctrl;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   k      = 0;
    logic [3:0] lzb_mask;

    seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS(4),
        .PRESCALE  (4),
        .CNT_W     (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h (k=%0d)", name, obs, exp, k);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        k++;
    endtask

    task automatic adv_to(input int target);
        while (k < target) cyc();
    endtask

    // Display must stay dark with no pending data; frame_done every 16 edges.
    task automatic check_dark(input int n);
        for (int j = 0; j < n; j++) begin
            cyc();
            chk("dark_en", 32'(bus.digit_en), 32'hf);
            chk("dark_nib", 32'(bus.nibble_out), 32'h0);
            chk("dark_fd", 32'(bus.frame_done), 32'((k % 16) == 0));
            chk("dark_pend", 32'(bus.pending), 32'h0);
        end
    endtask

    // Checks one full frame; call with k one edge before a frame boundary.
    task automatic check_frame(input logic [15:0] val, input logic [3:0] blank);
        int idx;
        int cnt;
        logic [3:0] exp_en;
        for (int j = 0; j < 16; j++) begin
            cyc();
            if (j == 0) bus.load = 1'b0;
            idx    = j / 4;
            cnt    = j % 4;
            exp_en = 4'hf;
            if (cnt != 0 && !blank[idx]) exp_en[idx] = 1'b0;
            chk("frm_nib", 32'(bus.nibble_out), 32'(val[4*idx +: 4]));
            chk("frm_en", 32'(bus.digit_en), 32'(exp_en));
            chk("frm_fd", 32'(bus.frame_done), 32'(j == 0));
        end
    endtask

    initial begin
`ifdef LEADING_ZERO_BLANK_EN
        lzb_mask = 4'b1100;
`else
        lzb_mask = 4'b0000;
`endif
        rst          = 1'b0;
        bus.load     = 1'b0;
        bus.value_in = '0;
        bus.blank_in = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_en", 32'(bus.digit_en), 32'hf);
        chk("rst_nib", 32'(bus.nibble_out), 32'h0);
        chk("rst_pend", 32'(bus.pending), 32'h0);
        chk("rst_fd", 32'(bus.frame_done), 32'h0);
        rst = 1'b1;
        k   = 0;

        // 1: no load, dark for 32 cycles
        check_dark(32);

        // 2: load 1234, shown from the first boundary
        adv_to(34);
        bus.load = 1'b1; bus.value_in = 16'h1234; bus.blank_in = 4'b0000;
        cyc();
        bus.load = 1'b0;
        chk("t2_pend", 32'(bus.pending), 32'h1);
        adv_to(47);
        chk("t2_pend_pre", 32'(bus.pending), 32'h1);
        check_frame(16'h1234, 4'b0000);
        chk("t2_pend_post", 32'(bus.pending), 32'h0);

        // 3: last load before the boundary wins
        adv_to(65);
        bus.load = 1'b1; bus.value_in = 16'hAAAA;
        cyc();
        bus.load = 1'b0;
        cyc();
        bus.load = 1'b1; bus.value_in = 16'h5555;
        cyc();
        bus.load = 1'b0;
        adv_to(79);
        check_frame(16'h5555, 4'b0000);
        chk("t3_pend_post", 32'(bus.pending), 32'h0);

        // 4: load on the boundary edge is deferred one frame
        adv_to(97);
        bus.load = 1'b1; bus.value_in = 16'h1234;
        cyc();
        bus.load = 1'b0;
        chk("t4_pend", 32'(bus.pending), 32'h1);
        adv_to(111);
        bus.load = 1'b1; bus.value_in = 16'hBEEF;
        check_frame(16'h1234, 4'b0000);
        chk("t4_pend_mid", 32'(bus.pending), 32'h1);
        check_frame(16'hBEEF, 4'b0000);
        chk("t4_pend_post", 32'(bus.pending), 32'h0);

        // 5: blank mask, and leading zeros
        adv_to(145);
        bus.load = 1'b1; bus.value_in = 16'h8888; bus.blank_in = 4'b0101;
        cyc();
        bus.load = 1'b0; bus.blank_in = 4'b0000;
        adv_to(159);
        check_frame(16'h8888, 4'b0101);
        adv_to(177);
        bus.load = 1'b1; bus.value_in = 16'h0070;
        cyc();
        bus.load = 1'b0;
        adv_to(191);
        check_frame(16'h0070, lzb_mask);

        // 6: reset mid-dwell on digit 2 with a pending load
        adv_to(209);
        bus.load = 1'b1; bus.value_in = 16'h1234;
        cyc();
        bus.load = 1'b0;
        chk("t6_pend", 32'(bus.pending), 32'h1);
        adv_to(218);
        chk("t6_en_pre", 32'(bus.digit_en), lzb_mask[2] ? 32'hf : 32'hb);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_en", 32'(bus.digit_en), 32'hf);
        chk("t6_rst_nib", 32'(bus.nibble_out), 32'h0);
        chk("t6_rst_pend", 32'(bus.pending), 32'h0);
        chk("t6_rst_fd", 32'(bus.frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        k   = 0;
        check_dark(32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one Decoder_7seg instance across NUM_DIGITS common-anode digits.
- Each digit gets a fixed dwell period. The controller drives the decoder's 4-bit input and one-hot active-low digit enables.
- A load handshake captures new display data into a shadow register. Shadow data is applied only at a frame boundary, so a frame never mixes old and new digits.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8)
- PRESCALE, 1000, clock cycles per digit dwell (>= 2)
- CNT_W, 10, prescaler width; must satisfy 2**CNT_W >= PRESCALE

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- load  input  1  single-cycle strobe; capture value_in/blank_in into shadow
- value_in  input  4*NUM_DIGITS  digit nibbles; digit i = value_in[4i+3:4i]
- blank_in  input  NUM_DIGITS  per-digit blank mask, 1 = digit dark
- nibble_out  output  4  to decoder bits_in; nibble of the currently scanned digit
- digit_en  output  NUM_DIGITS  active-low one-hot anode enables
- pending  output  1  shadow holds data not yet applied
- frame_done  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - prescaler=0, index=0
  - active value=0, active blank=all 1s
  - shadow=0, pending=0, frame_done=0
  - nibble_out=4'h0, digit_en=all 1s (display dark)
- Prescaler:
  - counts 0..PRESCALE-1, then wraps to 0.
  - Terminal count (PRESCALE-1) is the dwell boundary: index increments; NUM_DIGITS-1 wraps to 0.
- Frame boundary = dwell boundary with index==NUM_DIGITS-1. On that edge:
  - frame_done=1 for exactly one cycle.
  - If pending=1: active <= shadow and pending <= 0.
- Outputs are registered and updated each edge from the next-state index/count:
  - nibble_out = active nibble[index].
  - digit_en bit index = 0 only when both hold: prescaler != 0 (one-cycle dead time at the start of every dwell, anti-ghosting) and active blank[index]=0. Otherwise all bits are 1.
  - At most one digit_en bit is low at any time.
- Load handshake:
  - load=1 captures value_in/blank_in into shadow; pending=1 from the next cycle.
  - Multiple loads before a boundary: last one wins.
  - load on the same edge as a frame boundary: the boundary transfers the previous shadow contents (if pending=1). The new data goes to shadow and pending stays/becomes 1. It is applied at the following frame boundary.
- Reset mid-frame: everything returns to reset values immediately, including any pending load, which is discarded. Scanning resumes at digit 0, prescaler 0, on the first edge after rst deasserts.
- Frame period = NUM_DIGITS*PRESCALE cycles. Worst-case load-to-display latency = frame period + 1 cycle.

Optional Feature:
- LEADING_ZERO_BLANK_EN
- Defined: when shadow data is transferred to active, every digit above the highest nonzero nibble is additionally blanked (ORed into the blank mask). Digit 0 is never suppressed, so value 0 shows a single "0".
- Undefined: blank mask is used exactly as loaded; leading zeros are displayed.

Test Plan (NUM_DIGITS=4, PRESCALE=4):
1. Release reset with no load -> digit_en stays 4'b1111 for 32 cycles; frame_done pulses every 16 cycles; nibble_out=0.
2. load value_in=16'h1234, blank_in=4'b0000 at cycle 2 -> pending=1 until the first frame boundary. Then each dwell shows nibble_out 4,3,2,1 with digit_en 1110,1101,1011,0111. Each enable is low for 3 of 4 cycles (dead cycle first).
3. load 16'hAAAA, then 16'h5555 two cycles later, same frame -> after the boundary only 5s are displayed; AAAA is never shown.
4. load 16'hBEEF exactly on the frame-boundary edge while pending holds 16'h1234 -> next frame shows 1234; the frame after shows BEEF; pending clears only after the second boundary.
5. blank_in=4'b0101 with value 16'h8888 -> digits 0 and 2 keep digit_en high for their whole dwell; digits 1 and 3 enable normally. With LEADING_ZERO_BLANK_EN, value 16'h0070 -> digits 3 and 2 dark, digits 1 and 0 lit.
6. Assert rst for 1 cycle mid-dwell on digit 2 with pending=1 -> outputs go dark asynchronously, pending=0, scan restarts at digit 0, display stays dark until a new load and its frame boundary.
